// File: rtl/spi_dac_frame_receiver.sv
// Rebuilds 16-bit DAC SPI frames in the clock_50Mhz domain as a loopback checker.
// Publishes the 12-bit sample and power-down bits, and flags short frames.
`timescale 1ns/1ps
module spi_dac_frame_receiver #(
    parameter int unsigned FrameBits  = 16,
    parameter int unsigned SyncStages = 2
) (
    input  logic        clock_50Mhz,
    input  logic        reset,
    input  logic        input_SPI_SCLK,
    input  logic        input_SPI_SYNC_n,
    input  logic        input_SPI_DIN,
    output logic [11:0] outputSample,
    output logic [1:0]  outputPowerDown,
    output logic        sampleReady,
    output logic        frameError,
    output logic        isReceiving,
    output logic [15:0] frameCount
);

    localparam int unsigned CntW     = 5;
    localparam int unsigned PayloadW = 14;
    localparam int unsigned WarmMax  = SyncStages + 1;
    localparam int unsigned WarmW    = $clog2(WarmMax + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE_WAIT} state_t;

    logic [SyncStages-1:0] sclk_sync_q, syncn_sync_q, din_sync_q;
    logic                  sclk_prev_q, syncn_prev_q;
    logic [WarmW-1:0]      warm_q;
    logic                  sclk_fall_q, syncn_fall_q, syncn_rise_q, bit_q;
    logic                  warm_done;

    state_t                state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [PayloadW-1:0]   shift_q;
    logic [CntW-1:0]       bit_cnt_d;
    logic [PayloadW-1:0]   shift_d;
    logic                  frame_full;

    assign warm_done  = (warm_q == WarmW'(WarmMax));
    assign bit_cnt_d  = bit_cnt_q + CntW'(1);
    assign shift_d    = {shift_q[PayloadW-2:0], bit_q};
    assign frame_full = sclk_fall_q && (bit_cnt_d == CntW'(FrameBits));

    // Synchronizers and registered edge pulses; edges stay masked until the chains
    // hold real pin values, so a SYNC_n already low at reset is never taken as a start.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            sclk_sync_q  <= '1;
            syncn_sync_q <= '1;
            din_sync_q   <= '0;
            sclk_prev_q  <= 1'b1;
            syncn_prev_q <= 1'b1;
            warm_q       <= '0;
            sclk_fall_q  <= 1'b0;
            syncn_fall_q <= 1'b0;
            syncn_rise_q <= 1'b0;
            bit_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SyncStages-2:0], input_SPI_SCLK};
            syncn_sync_q <= {syncn_sync_q[SyncStages-2:0], input_SPI_SYNC_n};
            din_sync_q   <= {din_sync_q[SyncStages-2:0], input_SPI_DIN};
            sclk_prev_q  <= sclk_sync_q[SyncStages-1];
            syncn_prev_q <= syncn_sync_q[SyncStages-1];
            if (!warm_done) begin
                warm_q <= warm_q + WarmW'(1);
            end
            sclk_fall_q  <= warm_done &  sclk_prev_q  & ~sclk_sync_q[SyncStages-1];
            syncn_fall_q <= warm_done &  syncn_prev_q & ~syncn_sync_q[SyncStages-1];
            syncn_rise_q <= warm_done & ~syncn_prev_q &  syncn_sync_q[SyncStages-1];
            bit_q        <= din_sync_q[SyncStages-1];
        end
    end

    // Frame FSM; only payload bits [13:0] are kept since [15:14] are don't-care.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            outputSample    <= '0;
            outputPowerDown <= '0;
            sampleReady     <= 1'b0;
            frameError      <= 1'b0;
            isReceiving     <= 1'b0;
            frameCount      <= '0;
        end else begin
            sampleReady <= 1'b0;
            frameError  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (syncn_fall_q) begin
                        bit_cnt_q   <= '0;
                        state_q     <= SHIFT;
                        isReceiving <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_fall_q) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                    end
                    // A final edge coinciding with SYNC_n rising still completes the frame.
                    if (frame_full) begin
                        outputSample    <= shift_d[11:0];
                        outputPowerDown <= shift_d[13:12];
                        sampleReady     <= 1'b1;
                        frameCount      <= frameCount + 16'(1);
                        state_q         <= syncn_rise_q ? IDLE : DONE_WAIT;
                        isReceiving     <= 1'b0;
                    end else if (syncn_rise_q) begin
                        frameError  <= 1'b1;
                        state_q     <= IDLE;
                        isReceiving <= 1'b0;
                    end
                end
                DONE_WAIT: begin
                    if (syncn_rise_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    isReceiving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Scoreboard bench: frame-level model queues expected events, monitor checks each pulse.
`timescale 1ns/1ps
module tb_spi_dac_frame_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, sync_n, din;
    logic [11:0] outputSample;
    logic [1:0]  outputPowerDown;
    logic        sampleReady, frameError, isReceiving;
    logic [15:0] frameCount;

    always #10 clk = ~clk;

    spi_dac_frame_receiver #(.FrameBits(16), .SyncStages(2)) dut (
        .clock_50Mhz      (clk),
        .reset            (reset),
        .input_SPI_SCLK   (sclk),
        .input_SPI_SYNC_n (sync_n),
        .input_SPI_DIN    (din),
        .outputSample     (outputSample),
        .outputPowerDown  (outputPowerDown),
        .sampleReady      (sampleReady),
        .frameError       (frameError),
        .isReceiving      (isReceiving),
        .frameCount       (frameCount)
    );

    typedef struct {
        bit          is_err;
        logic [11:0] sample;
        logic [1:0]  pd;
        logic [15:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [11:0] m_sample = '0;
    logic [1:0]  m_pd     = '0;
    logic [15:0] m_count  = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    task automatic clocks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(bit b, int half, bit rise_with_fall);
        din = b;
        clocks(half);
        sclk = 1'b0;
        if (rise_with_fall) sync_n = 1'b1;
        clocks(half);
        sclk = 1'b1;
    endtask

    // Model: the first 16 bits form the word when at least 16 edges arrive, else it is short.
    task automatic send_frame(logic [31:0] data, int nbits, int half, int gap, bit coinc);
        exp_t e;
        if (nbits >= 16) begin
            logic [15:0] w;
            w        = 16'(data >> (nbits - 16));
            m_sample = w[11:0];
            m_pd     = w[13:12];
            m_count  = m_count + 16'd1;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.sample = m_sample;
        e.pd     = m_pd;
        e.count  = m_count;
        exp_q.push_back(e);
        sync_n = 1'b0;
        clocks(half);
        for (int i = 0; i < nbits; i++) begin
            logic [31:0] d;
            d = data >> (nbits - 1 - i);
            clock_bit(d[0], half, coinc && (i == nbits - 1));
            if (i == 8) check("rx_mid_frame", 32'(isReceiving), 32'd1);
        end
        sync_n = 1'b1;
        clocks(gap);
    endtask

    task automatic settle();
        clocks(8);
        check("idle_after_frame", 32'(isReceiving), 32'd0);
        check("events_pending", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (sampleReady || frameError)) begin
            check("pulse_exclusive", 32'(sampleReady & frameError), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, sampleReady, frameError}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_error", 32'(frameError), 32'(e.is_err));
                check("outputSample", 32'(outputSample), 32'(e.sample));
                check("outputPowerDown", 32'(outputPowerDown), 32'(e.pd));
                check("frameCount", 32'(frameCount), 32'(e.count));
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: timeout reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] data;
        int          nb;
        reset  = 1'b1;
        sclk   = 1'b1;
        sync_n = 1'b1;
        din    = 1'b0;
        clocks(3);
        check("rst_sample", 32'(outputSample), 32'd0);
        check("rst_pd", 32'(outputPowerDown), 32'd0);
        check("rst_count", 32'(frameCount), 32'd0);
        check("rst_ready", 32'(sampleReady), 32'd0);
        check("rst_error", 32'(frameError), 32'd0);
        check("rst_rx", 32'(isReceiving), 32'd0);
        reset = 1'b0;
        clocks(6);

        // good frame, short frame, over-long frame
        send_frame(32'h3ABC, 16, 4, 4, 1'b0);
        settle();
        check("good_sample", 32'(outputSample), 32'hABC);
        check("good_pd", 32'(outputPowerDown), 32'h3);
        check("good_count", 32'(frameCount), 32'd1);
        send_frame(32'h1A5, 9, 4, 4, 1'b0);
        settle();
        check("short_keeps_sample", 32'(outputSample), 32'hABC);
        send_frame((32'h0FFF << 4) | 32'($urandom_range(0, 15)), 20, 4, 4, 1'b0);
        settle();
        check("long_sample", 32'(outputSample), 32'hFFF);

        // reset mid-frame while SYNC_n stays low, then the frame keeps clocking
        sync_n = 1'b0;
        clocks(4);
        for (int i = 0; i < 7; i++) clock_bit(1'($urandom), 4, 1'b0);
        reset = 1'b1;
        clocks(1);
        reset    = 1'b0;
        m_sample = '0;
        m_pd     = '0;
        m_count  = '0;
        for (int i = 0; i < 9; i++) clock_bit(1'($urandom), 4, 1'b0);
        sync_n = 1'b1;
        settle();
        check("postrst_sample", 32'(outputSample), 32'd0);
        check("postrst_pd", 32'(outputPowerDown), 32'd0);
        check("postrst_count", 32'(frameCount), 32'd0);
        send_frame(32'h0123, 16, 4, 4, 1'b0);
        settle();
        check("after_rst_sample", 32'(outputSample), 32'h123);
        check("after_rst_count", 32'(frameCount), 32'd1);

        // back-to-back with minimum gaps
        send_frame(32'h0000, 16, 4, 3, 1'b0);
        send_frame(32'h0FFF, 16, 4, 3, 1'b0);
        send_frame(32'h0800, 16, 4, 3, 1'b0);
        settle();
        check("b2b_count", 32'(frameCount), 32'd4);

        // randomized frames, including zero-edge and over-long ones
        for (int k = 0; k < 24; k++) begin
            data = $urandom;
            nb   = $urandom_range(0, 20);
            send_frame(data, nb, $urandom_range(3, 6), $urandom_range(3, 8), 1'b0);
        end
        settle();

        // counter wrap with SYNC_n rising on the 16th falling edge
        @(negedge clk);
        force dut.frameCount = 16'hFFFF;
        clocks(1);
        release dut.frameCount;
        m_count = 16'hFFFF;
        clocks(2);
        send_frame(32'h2D5A, 16, 4, 4, 1'b1);
        settle();
        check("wrap_count", 32'(frameCount), 32'd0);
        check("wrap_sample", 32'(outputSample), 32'hD5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
